// File: rtl/gold_nic.sv
// gold_nic: network interface between a processing element and the PE port
// of a gold_router. It holds one outbound packet until the ring polarity
// matches its virtual channel, and one inbound packet until the processor
// reads it. The processor sees a four-entry register file.
module gold_nic (
    input  logic        clk,
    input  logic        reset,
    input  logic [1:0]  addr,
    input  logic [63:0] d_in,
    output logic [63:0] d_out,
    input  logic        nicEn,
    input  logic        nicWrEn,
    output logic        net_so,
    input  logic        net_ro,
    output logic [63:0] net_do,
    input  logic        net_polarity,
    input  logic        net_si,
    output logic        net_ri,
    input  logic [63:0] net_di
);

    localparam int DATA_W = 64;
    localparam int VC_BIT = DATA_W - 1;

    localparam logic [1:0] ADDR_IN_BUF   = 2'b00;
    localparam logic [1:0] ADDR_IN_STAT  = 2'b01;
    localparam logic [1:0] ADDR_OUT_BUF  = 2'b10;
    localparam logic [1:0] ADDR_OUT_STAT = 2'b11;

    // Each channel is EMPTY/FULL; the encoding doubles as the full bit.
    typedef enum logic {
        CH_EMPTY = 1'b0,
        CH_FULL  = 1'b1
    } chan_state_t;

    chan_state_t out_state, out_state_nxt;
    chan_state_t in_state,  in_state_nxt;

    logic [DATA_W-1:0] out_buf;
    logic [DATA_W-1:0] in_buf;
    logic [DATA_W-1:0] rd_data;

    logic out_full;
    logic in_full;
    logic rd_req;
    logic wr_req;
    logic wr_out_buf;
    logic rd_in_buf;
    logic vc_match;
    logic capture;
    logic load_out;
    logic load_in;

    assign out_full = (out_state == CH_FULL);
    assign in_full  = (in_state == CH_FULL);

    // Processor access decode. A write to the output buffer only lands when
    // the buffer is empty, so a pending packet is never overwritten.
    assign rd_req     = nicEn & ~nicWrEn;
    assign wr_req     = nicEn & nicWrEn;
    assign wr_out_buf = wr_req & (addr == ADDR_OUT_BUF) & ~out_full;
    assign rd_in_buf  = rd_req & (addr == ADDR_IN_BUF);

    // Send handshake: inject only when the ring's current polarity serves
    // the packet's virtual channel. Reset masks both handshakes so nothing
    // moves on a reset edge.
    assign vc_match = (out_buf[VC_BIT] == net_polarity);
    assign net_so   = out_full & net_ro & vc_match & ~reset;
    assign net_do   = out_buf;

    // Receive handshake: ready whenever the input buffer is free.
    assign net_ri  = ~in_full & ~reset;
    assign capture = net_si & net_ri;

    // Send-channel next state: a write fills, an injection drains.
    always_comb begin
        out_state_nxt = out_state;
        load_out      = 1'b0;
        case (out_state)
            CH_EMPTY: begin
                if (wr_out_buf) begin
                    out_state_nxt = CH_FULL;
                    load_out      = 1'b1;
                end
            end
            CH_FULL: begin
                if (net_so) begin
                    out_state_nxt = CH_EMPTY;
                end
            end
            default: out_state_nxt = CH_EMPTY;
        endcase
    end

    // Receive-channel next state: a capture fills, a buffer read drains.
    // A read while already empty leaves it empty; if a capture lands in the
    // same cycle the new packet is kept rather than dropped.
    always_comb begin
        in_state_nxt = in_state;
        load_in      = 1'b0;
        case (in_state)
            CH_EMPTY: begin
                if (capture) begin
                    in_state_nxt = CH_FULL;
                    load_in      = 1'b1;
                end
            end
            CH_FULL: begin
                if (rd_in_buf) begin
                    in_state_nxt = CH_EMPTY;
                end
            end
            default: in_state_nxt = CH_EMPTY;
        endcase
    end

    // Register-file read mux, using the state as it stood before this edge.
    always_comb begin
        rd_data = '0;
        case (addr)
            ADDR_IN_BUF:   rd_data = in_buf;
            ADDR_IN_STAT:  rd_data = {{(DATA_W-1){1'b0}}, in_full};
            ADDR_OUT_BUF:  rd_data = out_buf;
            ADDR_OUT_STAT: rd_data = {{(DATA_W-1){1'b0}}, out_full};
            default:       rd_data = '0;
        endcase
    end

    // Channel state registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_state <= CH_EMPTY;
            in_state  <= CH_EMPTY;
        end else begin
            out_state <= out_state_nxt;
            in_state  <= in_state_nxt;
        end
    end

    // Packet buffers; reset discards any pending packet contents too.
    always_ff @(posedge clk) begin
        if (reset) begin
            out_buf <= '0;
            in_buf  <= '0;
        end else begin
            if (load_out) begin
                out_buf <= d_in;
            end
            if (load_in) begin
                in_buf <= net_di;
            end
        end
    end

    // Registered read data; holds when no read is requested.
    always_ff @(posedge clk) begin
        if (reset) begin
            d_out <= '0;
        end else if (rd_req) begin
            d_out <= rd_data;
        end
    end

endmodule

// File: tb/tb_gold_nic.sv
// Scoreboard bench for gold_nic: a queue-based reference model predicts the
// handshake outputs and the registered read data for every driven cycle; two
// monitors compare those predictions against the DUT.
module tb_gold_nic;

    logic        clk;
    logic        reset;
    logic [1:0]  addr;
    logic [63:0] d_in;
    logic [63:0] d_out;
    logic        nicEn;
    logic        nicWrEn;
    logic        net_so;
    logic        net_ro;
    logic [63:0] net_do;
    logic        net_polarity;
    logic        net_si;
    logic        net_ri;
    logic [63:0] net_di;

    gold_nic dut (
        .clk          (clk),
        .reset        (reset),
        .addr         (addr),
        .d_in         (d_in),
        .d_out        (d_out),
        .nicEn        (nicEn),
        .nicWrEn      (nicWrEn),
        .net_so       (net_so),
        .net_ro       (net_ro),
        .net_do       (net_do),
        .net_polarity (net_polarity),
        .net_si       (net_si),
        .net_ri       (net_ri),
        .net_di       (net_di)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit        so;
        bit        ri;
        bit [63:0] ndo;
        bit [63:0] dout;
    } exp_t;

    exp_t        cyc_q[$];
    bit   [63:0] dout_q[$];

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model state: pending packets as queues, plus last buffer
    // contents (which stay visible after a packet leaves).
    bit [63:0] m_out_q[$];
    bit [63:0] m_in_q[$];
    bit [63:0] m_out_data = '0;
    bit [63:0] m_in_data  = '0;
    bit [63:0] m_dout     = '0;

    // Stimulus for the next cycle.
    bit        s_rst, s_en, s_wr, s_ro, s_pol, s_si;
    bit [1:0]  s_a;
    bit [63:0] s_din, s_di;

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    endtask

    // Drive one cycle of stimulus, predict its outcome, queue the prediction.
    task automatic step();
        exp_t e;
        bit   in_was_full;
        bit   out_was_full;
        @(posedge clk);
        #2;
        reset        = s_rst;
        nicEn        = s_en;
        nicWrEn      = s_wr;
        addr         = s_a;
        d_in         = s_din;
        net_ro       = s_ro;
        net_polarity = s_pol;
        net_si       = s_si;
        net_di       = s_di;

        out_was_full = (m_out_q.size() != 0);
        in_was_full  = (m_in_q.size() != 0);
        e.so  = !s_rst && out_was_full && s_ro && (m_out_q[0][63] == s_pol);
        e.ri  = !s_rst && !in_was_full;
        e.ndo = m_out_data;

        if (s_rst) begin
            m_out_q.delete();
            m_in_q.delete();
            m_out_data = '0;
            m_in_data  = '0;
            m_dout     = '0;
        end else begin
            if (s_en && !s_wr) begin
                case (s_a)
                    2'b00: begin
                        m_dout = m_in_data;
                        m_in_q.delete();
                    end
                    2'b01: m_dout = {63'b0, in_was_full};
                    2'b10: m_dout = m_out_data;
                    default: m_dout = {63'b0, out_was_full};
                endcase
            end
            if (s_en && s_wr && s_a == 2'b10 && !out_was_full) begin
                m_out_q.push_back(s_din);
                m_out_data = s_din;
            end else if (e.so) begin
                void'(m_out_q.pop_front());
            end
            if (s_si && e.ri) begin
                m_in_q.push_back(s_di);
                m_in_data = s_di;
            end
        end
        e.dout = m_dout;
        cyc_q.push_back(e);
    endtask

    task automatic set(input bit rst, input bit en, input bit wr, input bit [1:0] a,
                       input bit [63:0] din, input bit ro, input bit pol,
                       input bit si, input bit [63:0] di);
        s_rst = rst; s_en = en; s_wr = wr; s_a = a; s_din = din;
        s_ro = ro; s_pol = pol; s_si = si; s_di = di;
        step();
    endtask

    task automatic rd(input bit [1:0] a, input bit ro, input bit pol);
        set(0, 1, 0, a, '0, ro, pol, 0, '0);
    endtask

    task automatic wr(input bit [63:0] din, input bit ro, input bit pol);
        set(0, 1, 1, 2'b10, din, ro, pol, 0, '0);
    endtask

    task automatic idle(input bit ro, input bit pol);
        set(0, 0, 0, 2'b00, '0, ro, pol, 0, '0);
    endtask

    // Handshake monitor: mid-cycle, compare combinational outputs.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (cyc_q.size() != 0) begin
                e = cyc_q.pop_front();
                chk("net_so", {63'b0, net_so}, {63'b0, e.so});
                chk("net_ri", {63'b0, net_ri}, {63'b0, e.ri});
                chk("net_do", net_do, e.ndo);
                dout_q.push_back(e.dout);
            end
        end
    end

    // Read-data monitor: just after the edge, compare the registered d_out.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (dout_q.size() != 0) chk("d_out", d_out, dout_q.pop_front());
        end
    end

    initial begin
        bit pol;
        int guard;
        reset = 1'b1; nicEn = 0; nicWrEn = 0; addr = '0; d_in = '0;
        net_ro = 1'b1; net_polarity = 0; net_si = 1'b1; net_di = '0;
        repeat (2) @(posedge clk);

        // Reset held with traffic offered on both sides.
        set(1, 0, 0, 2'b00, '0, 1, 0, 1, 64'hDEAD);
        set(1, 0, 0, 2'b00, '0, 1, 1, 1, 64'hBEEF);
        rd(2'b01, 1, 0);
        rd(2'b11, 1, 0);

        // Send waits for matching polarity.
        pol = 0;
        wr(64'h8000_0000_0000_00AA, 1, pol);
        repeat (4) begin pol = ~pol; idle(1, pol); end
        rd(2'b11, 1, 0);

        // Backpressure and no overwrite.
        wr(64'h1, 0, 0);
        repeat (5) idle(0, 1);
        wr(64'h2, 0, 0);
        rd(2'b11, 0, 0);
        rd(2'b10, 0, 0);
        repeat (3) idle(1, 0);
        rd(2'b11, 1, 0);

        // Receive and hold.
        set(0, 0, 0, 2'b00, '0, 0, 0, 1, 64'h0123_4567_89AB_CDEF);
        rd(2'b01, 0, 0);
        set(0, 0, 0, 2'b00, '0, 0, 0, 1, 64'hFFFF_0000_FFFF_0000);
        rd(2'b00, 0, 0);
        idle(0, 0);
        rd(2'b01, 0, 0);

        // Simultaneous send and receive.
        wr(64'h0000_0000_0000_0055, 0, 1);
        set(0, 0, 0, 2'b00, '0, 1, 0, 1, 64'h7777_1111_2222_3333);
        rd(2'b11, 0, 0);
        rd(2'b01, 0, 0);
        rd(2'b00, 0, 0);

        // Reset with both buffers full.
        wr(64'h8000_0000_0000_0099, 0, 1);
        set(0, 0, 0, 2'b00, '0, 0, 1, 1, 64'h4444_5555_6666_7777);
        set(1, 0, 0, 2'b00, '0, 1, 1, 1, 64'h1);
        rd(2'b01, 1, 0);
        rd(2'b11, 1, 0);
        rd(2'b00, 1, 0);

        // Randomized traffic.
        for (int i = 0; i < 400; i++) begin
            s_rst = ($urandom_range(0, 63) == 0);
            s_en  = $urandom_range(0, 1);
            s_wr  = $urandom_range(0, 1);
            s_a   = 2'($urandom_range(0, 3));
            if (s_wr && $urandom_range(0, 1)) s_a = 2'b10;
            s_din = {$urandom, $urandom};
            s_ro  = ($urandom_range(0, 3) != 0);
            s_pol = $urandom_range(0, 1);
            s_si  = $urandom_range(0, 1);
            s_di  = {$urandom, $urandom};
            if (s_en && !s_wr && s_a == 2'b00 && s_si && m_in_q.size() == 0) s_a = 2'b01;
            step();
        end

        idle(0, 0);
        guard = 0;
        while ((cyc_q.size() != 0 || dout_q.size() != 0) && guard < 10) begin
            @(posedge clk);
            guard++;
        end
        @(posedge clk);
        chk("drain", 64'(cyc_q.size() + dout_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/gold_nic.md
# gold_nic

Network interface controller that sits between a processing element and the PE port of one `gold_router` in the four-node gold ring. It is the opposite end of the router's PE handshake.
- On the send side it holds one packet written by the processor and injects it into the router when the router is ready and the ring polarity matches the packet's virtual channel.
- On the receive side it accepts one ejected packet from the router and holds it until the processor reads it.
- The processor sees a four-entry memory-mapped register file.

## Interface
Parameters:
- none; data width fixed at 64, address width fixed at 2.

Ports:
- Clock and reset: one clock `clk`; reset is synchronous and active-high (`reset`).
- `clk`  in  1  rising-edge clock shared with the ring.
- `reset`  in  1  synchronous, active-high reset.
- `addr`  in  2  register select: 00 input buffer, 01 input status, 10 output buffer, 11 output status.
- `d_in`  in  64  processor write data.
- `d_out`  out  64  processor read data (registered).
- `nicEn`  in  1  register access enable.
- `nicWrEn`  in  1  1 = write, 0 = read; qualified by `nicEn`.
- `net_so`  out  1  send valid to router; drives router `pesi`.
- `net_ro`  in  1  router ready; from router `peri`.
- `net_do`  out  64  packet to router; drives router `pedi`.
- `net_polarity`  in  1  ring polarity from the router.
- `net_si`  in  1  router eject valid; from router `peso`.
- `net_ri`  out  1  NIC ready to accept; drives router `pero`.
- `net_di`  in  64  ejected packet; from router `pedo`.

## Operation
- **State:**
  - `out_buf[63:0]` and `out_full` (send channel).
  - `in_buf[63:0]` and `in_full` (receive channel).
  - Each channel is a two-state machine, EMPTY/FULL, encoded by its full bit.
- **Packet field used:** bit 63 = virtual channel (VC). All other bits pass through unmodified.
- **Processor write** (`nicEn=1`, `nicWrEn=1`):
  - addr 10 while `out_full=0`: `out_buf<=d_in`, `out_full<=1`.
  - addr 10 while `out_full=1`: ignored; the buffer is not overwritten.
  - Writes to 00, 01 and 11 are ignored.
- **Processor read** (`nicEn=1`, `nicWrEn=0`):
  - addr 00: `d_out<=in_buf`, `in_full<=0`. The buffer is cleared by the read even if it was already empty.
  - addr 01: `d_out<={63'b0,in_full}`.
  - addr 10: `d_out<=out_buf`; no side effect.
  - addr 11: `d_out<={63'b0,out_full}`.
  - `nicEn=0`: `d_out` holds its value.
- **Send:**
  - `net_so = out_full & net_ro & (out_buf[63]==net_polarity) & ~reset` (combinational).
  - `net_do = out_buf` at all times.
  - On a clock edge with `net_so=1`: `out_full<=0`.
- **Receive:**
  - `net_ri = ~in_full & ~reset` (combinational).
  - On a clock edge with `net_si & net_ri`: `in_buf<=net_di`, `in_full<=1`.
  - If `net_si=1` while `net_ri=0`, the NIC does not capture. Holding the packet is the router's responsibility.
- **Simultaneous events:**
  - Write to 10 in the same cycle as a send: the write is ignored, because `out_full` was 1. The processor must poll 11.
  - Read of 00 in the same cycle as `net_si`: no capture, because `net_ri` was 0. Capture becomes possible the following cycle.
  - Send-side and receive-side events are fully independent and may occur in the same cycle.

## Timing
- **Reset:** while `reset=1` at a rising edge, the following clear to 0: `out_buf`, `in_buf`, `out_full`, `in_full`, `d_out`. `net_so=0` and `net_ri=0` while `reset` is high.
- **Reset mid-operation:** a pending output or input packet is discarded. No send or accept occurs on the reset edge.
- **Read latency:** 1 cycle. `d_out` is valid the cycle after the `nicEn` read request.
- **Write to send:**
  - A write at edge N makes `out_full=1` after N.
  - `net_so` can assert in cycle N+1 if `net_ro=1` and polarity matches.
  - Otherwise `net_so` waits, including across polarity toggles, until both conditions hold.
- **Receive to read:** a capture at edge N makes status 01 read 1 from a request issued in cycle N+1 onward.
- **Throughput:** at most one packet per direction per cycle is never exceeded.
  - Send: one packet per two cycles sustained (write then inject).
  - Receive: one packet per two cycles (accept then read).

## Test plan
- **Reset:** hold `reset` 2 cycles with `net_si=1`, `net_ro=1`.
  - Required: `net_so=0`, `net_ri=0`, `d_out=0`.
  - Required after release: status 01 and 11 both read 0, and `net_ri=1`.
- **Send with polarity:**
  - Write `64'h8000_0000_0000_00AA` to addr 10, with `net_ro=1` and `net_polarity` alternating each cycle.
  - Required: `net_so=1` only in cycles where polarity=1, with `net_do=64'h8000_0000_0000_00AA`.
  - Required after that edge: status 11 reads 0.
- **Backpressure and overwrite:**
  - Write `64'h1` to addr 10 with `net_ro=0` for 5 cycles, then write `64'h2` to addr 10.
  - Required: status 11 reads 1 and `net_do` stays `64'h1`.
  - Raise `net_ro` with polarity=0. Required: exactly one send of `64'h1`.
- **Receive and hold:**
  - Pulse `net_si=1` with `net_di=64'h0123_4567_89AB_CDEF`.
  - Required: `net_ri` drops the next cycle, and status 01 reads 1.
  - Present a second packet. Required: it is not captured.
  - Read addr 00. Required: `d_out=64'h0123_4567_89AB_CDEF` one cycle later, and `net_ri` returns to 1.
- **Simultaneous send and receive:**
  - In the same cycle, the send condition is true and `net_si=1` with `net_ri=1`.
  - Required: both complete, giving `out_full=0` and `in_full=1`.
- **Reset mid-operation:**
  - With both buffers full, assert `reset` for 1 cycle.
  - Required: both status registers read 0, no `net_so` pulse, and read of addr 00 returns 0.
